// File: rtl/fiat_25519_udiv_pkg.sv
// Shared types and default widths for the carry-square restoring divider.
package fiat_25519_udiv_pkg;

    localparam int unsigned DIN0_WIDTH_DEFAULT = 7;
    localparam int unsigned DIN1_WIDTH_DEFAULT = 5;
    localparam int unsigned DOUT_WIDTH_DEFAULT = 7;
    localparam int unsigned CNT_WIDTH_DEFAULT  = $clog2(DIN0_WIDTH_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fiat_25519_udiv_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module fiat_25519_udiv_step #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] prem,
    input  logic         dvd_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] next_rem_c,
    output logic         q_bit_c
);

    logic [W:0] trial;

    // Trial subtraction; the result always fits W bits because prem < divisor on entry.
    always_comb begin
        trial      = {prem, dvd_bit};
        q_bit_c    = (trial >= {1'b0, divisor});
        next_rem_c = q_bit_c ? W'(trial - {1'b0, divisor}) : trial[W-1:0];
    end

endmodule

// File: rtl/fiat_25519_carry_square_udiv_7ns_5ns_7_seq.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, ap start/done handshake.
// Optional divide-by-zero flag enabled by defining FIAT_25519_UDIV_DIV_ZERO_FLAG_EN.
module fiat_25519_carry_square_udiv_7ns_5ns_7_seq
    import fiat_25519_udiv_pkg::*;
#(
    parameter int unsigned din0_WIDTH = DIN0_WIDTH_DEFAULT,
    parameter int unsigned din1_WIDTH = DIN1_WIDTH_DEFAULT,
    parameter int unsigned dout_WIDTH = DOUT_WIDTH_DEFAULT
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  ap_start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero
);

    localparam int unsigned CNT_W = $clog2(din0_WIDTH);

    state_t                  state_q, state_d;
    logic [din0_WIDTH-1:0]   dvd_q, dvd_d;
    logic [din1_WIDTH-1:0]   dvs_q, dvs_d;
    logic [din1_WIDTH-1:0]   prem_q, prem_d;
    logic [dout_WIDTH-1:0]   quot_q, quot_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ready_d, done_d;
    logic [dout_WIDTH-1:0]   dout_d;
    logic [din1_WIDTH-1:0]   rem_d;
    logic [din1_WIDTH-1:0]   step_rem;
    logic                    step_q;

    fiat_25519_udiv_step #(
        .W (din1_WIDTH)
    ) u_step (
        .prem       (prem_q),
        .dvd_bit    (dvd_q[din0_WIDTH-1]),
        .divisor    (dvs_q),
        .next_rem_c (step_rem),
        .q_bit_c    (step_q)
    );

    // State register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ap_start) state_d = CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and handshake next values; ready/done default low so they pulse for one ce cycle.
    always_comb begin
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        done_d  = 1'b0;
        dout_d  = dout;
        rem_d   = rem;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    dvd_d   = din0;
                    dvs_d   = din1;
                    prem_d  = '0;
                    quot_d  = '0;
                    cnt_d   = CNT_W'(din0_WIDTH - 1);
                    ready_d = 1'b1;
                end
            end
            CALC: begin
                dvd_d  = dvd_q << 1;
                prem_d = step_rem;
                quot_d = {quot_q[dout_WIDTH-2:0], step_q};
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
            DONE: begin
                dout_d = quot_q;
                rem_d  = prem_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers; everything freezes while ce is low.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            dvd_q    <= '0;
            dvs_q    <= '0;
            prem_q   <= '0;
            quot_q   <= '0;
            cnt_q    <= '0;
            ap_ready <= 1'b0;
            ap_done  <= 1'b0;
            dout     <= '0;
            rem      <= '0;
        end else if (ce) begin
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            prem_q   <= prem_d;
            quot_q   <= quot_d;
            cnt_q    <= cnt_d;
            ap_ready <= ready_d;
            ap_done  <= done_d;
            dout     <= dout_d;
            rem      <= rem_d;
        end
    end

    assign ap_idle = (state_q == IDLE);

`ifdef FIAT_25519_UDIV_DIV_ZERO_FLAG_EN
    logic dz_pend_q;
    logic dz_q;

    // Capture the zero-divisor compare at acceptance, publish it alongside the quotient.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            dz_pend_q <= 1'b0;
            dz_q      <= 1'b0;
        end else if (ce) begin
            if (state_q == IDLE && ap_start) dz_pend_q <= (din1 == '0);
            if (state_q == DONE)             dz_q      <= dz_pend_q;
        end
    end

    assign div_by_zero = dz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_fiat_25519_carry_square_udiv_7ns_5ns_7_seq.sv
// Self-checking bench for the sequential restoring divider.
module tb_fiat_25519_carry_square_udiv_7ns_5ns_7_seq;

    logic       ap_clk;
    logic       ap_rst;
    logic       ce;
    logic       ap_start;
    logic [6:0] din0;
    logic [4:0] din1;
    logic       ap_ready;
    logic       ap_idle;
    logic       ap_done;
    logic [6:0] dout;
    logic [4:0] rem;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    fiat_25519_carry_square_udiv_7ns_5ns_7_seq dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ce          (ce),
        .ap_start    (ap_start),
        .din0        (din0),
        .din1        (din1),
        .ap_ready    (ap_ready),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .dout        (dout),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; observe settled values just after the edge.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Reference: plain integer division; a zero divisor gives all-ones and the low dividend bits.
    function automatic void model(input int a, input int b, output int q, output int r, output int dz);
        if (b == 0) begin
            q = 127;
            r = a % 32;
            dz = 1;
        end else begin
            q = a / b;
            r = a % b;
            dz = 0;
        end
`ifndef FIAT_25519_UDIV_DIV_ZERO_FLAG_EN
        dz = 0;
`endif
    endfunction

    // Start a division, wait for acceptance, then count cycles until ap_done (-1 on timeout).
    task automatic do_div(input int a, input int b, output int lat,
                          output logic [6:0] q, output logic [4:0] r, output logic dz);
        int guard;
        din0 = 7'(a);
        din1 = 5'(b);
        ap_start = 1'b1;
        guard = 0;
        lat = -1;
        do begin
            tick();
            guard++;
        end while (!ap_ready && guard < 20);
        ap_start = 1'b0;
        if (ap_ready) begin
            lat = 0;
            do begin
                tick();
                lat++;
            end while (!ap_done && lat < 40);
            if (!ap_done) lat = -1;
        end
        q = dout;
        r = rem;
        dz = div_by_zero;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ce = 1'b1; ap_start = 1'b0; din0 = '0; din1 = '0;
        repeat (3) tick();
        ap_rst = 1'b0;
        tick();
        checks++; if (ap_idle !== 1'b1)     begin errors++; $display("FAIL reset_idle: got %b want 1", ap_idle); end
        checks++; if (ap_ready !== 1'b0)    begin errors++; $display("FAIL reset_ready: got %b want 0", ap_ready); end
        checks++; if (ap_done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", ap_done); end
        checks++; if (dout !== 7'd0)        begin errors++; $display("FAIL reset_dout: got %0d want 0", dout); end
        checks++; if (rem !== 5'd0)         begin errors++; $display("FAIL reset_rem: got %0d want 0", rem); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    endtask

    task automatic test_directed();
        int a_tab [6] = '{100, 127, 5, 126, 45, 50};
        int b_tab [6] = '{7, 1, 31, 18, 0, 6};
        int lat, eq, er, edz;
        logic [6:0] q; logic [4:0] r; logic dz;
        for (int i = 0; i < 6; i++) begin
            model(a_tab[i], b_tab[i], eq, er, edz);
            do_div(a_tab[i], b_tab[i], lat, q, r, dz);
            checks++; if (lat != 8)          begin errors++; $display("FAIL dir_latency %0d/%0d: got %0d want 8", a_tab[i], b_tab[i], lat); end
            checks++; if (q !== 7'(eq))      begin errors++; $display("FAIL dir_quot %0d/%0d: got %0d want %0d", a_tab[i], b_tab[i], q, eq); end
            checks++; if (r !== 5'(er))      begin errors++; $display("FAIL dir_rem %0d/%0d: got %0d want %0d", a_tab[i], b_tab[i], r, er); end
            checks++; if (dz !== 1'(edz))    begin errors++; $display("FAIL dir_dbz %0d/%0d: got %b want %0d", a_tab[i], b_tab[i], dz, edz); end
            tick();
        end
    endtask

    task automatic test_random();
        int a, b, lat, eq, er, edz;
        logic [6:0] q; logic [4:0] r; logic dz;
        for (int i = 0; i < 25; i++) begin
            a = int'($urandom_range(0, 127));
            b = int'($urandom_range(0, 31));
            model(a, b, eq, er, edz);
            do_div(a, b, lat, q, r, dz);
            checks++; if (lat != 8)       begin errors++; $display("FAIL rnd_latency %0d/%0d: got %0d want 8", a, b, lat); end
            checks++; if (q !== 7'(eq))   begin errors++; $display("FAIL rnd_quot %0d/%0d: got %0d want %0d", a, b, q, eq); end
            checks++; if (r !== 5'(er))   begin errors++; $display("FAIL rnd_rem %0d/%0d: got %0d want %0d", a, b, r, er); end
            checks++; if (dz !== 1'(edz)) begin errors++; $display("FAIL rnd_dbz %0d/%0d: got %b want %0d", a, b, dz, edz); end
            repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    task automatic test_ce_stall();
        logic [6:0] prev_q; logic [4:0] prev_r;
        int lat, guard;
        prev_q = dout; prev_r = rem;
        din0 = 7'd100; din1 = 5'd7; ap_start = 1'b1;
        guard = 0;
        do begin tick(); guard++; end while (!ap_ready && guard < 20);
        checks++; if (ap_ready !== 1'b1) begin errors++; $display("FAIL ce_accept: got %b want 1", ap_ready); end
        // Keep ap_start high with other operands while calculating; it must be ignored.
        din0 = 7'd3; din1 = 5'd1;
        lat = 0;
        do begin
            tick();
            lat++;
            if (!ap_done) begin
                checks++;
                if (dout !== prev_q || rem !== prev_r) begin
                    errors++; $display("FAIL ce_hold_result: got %0d/%0d want %0d/%0d", dout, rem, prev_q, prev_r);
                end
            end
            if (lat == 2) begin ap_start = 1'b0; ce = 1'b0; end
            if (lat == 5) ce = 1'b1;
        end while (!ap_done && lat < 40);
        checks++; if (lat != 11 || !ap_done) begin errors++; $display("FAIL ce_latency: got %0d want 11", lat); end
        checks++; if (dout !== 7'd14) begin errors++; $display("FAIL ce_quot: got %0d want 14", dout); end
        checks++; if (rem !== 5'd2)   begin errors++; $display("FAIL ce_rem: got %0d want 2", rem); end
        ce = 1'b0;
        tick();
        checks++; if (ap_done !== 1'b1) begin errors++; $display("FAIL ce_done_held: got %b want 1", ap_done); end
        ce = 1'b1;
        tick();
        checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL ce_done_clear: got %b want 0", ap_done); end
        checks++; if (ap_idle !== 1'b1 || dout !== 7'd14) begin errors++; $display("FAIL ce_after: idle %b dout %0d want 1/14", ap_idle, dout); end
    endtask

    task automatic test_reset_mid();
        int lat, guard, done_cnt;
        logic [6:0] q; logic [4:0] r; logic dz;
        din0 = 7'd100; din1 = 5'd7; ap_start = 1'b1;
        guard = 0;
        do begin tick(); guard++; end while (!ap_ready && guard < 20);
        ap_start = 1'b0;
        repeat (4) tick();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got %b want 1", ap_idle); end
        checks++; if (dout !== 7'd0 || rem !== 5'd0) begin errors++; $display("FAIL rst_mid_result: got %0d/%0d want 0/0", dout, rem); end
        done_cnt = 0;
        repeat (12) begin tick(); if (ap_done) done_cnt++; end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_cnt); end
        do_div(50, 6, lat, q, r, dz);
        checks++; if (lat != 8)      begin errors++; $display("FAIL rst_fresh_latency: got %0d want 8", lat); end
        checks++; if (q !== 7'd8)    begin errors++; $display("FAIL rst_fresh_quot: got %0d want 8", q); end
        checks++; if (r !== 5'd2)    begin errors++; $display("FAIL rst_fresh_rem: got %0d want 2", r); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, guard;
        din0 = 7'd100; din1 = 5'd7; ap_start = 1'b1;
        guard = 0;
        do begin tick(); guard++; end while (!ap_ready && guard < 20);
        din0 = 7'd99; din1 = 5'd9;
        lat = 0;
        do begin tick(); lat++; end while (!ap_done && lat < 40);
        checks++; if (lat != 8 || !ap_done) begin errors++; $display("FAIL b2b_first_latency: got %0d want 8", lat); end
        checks++; if (dout !== 7'd14 || rem !== 5'd2) begin errors++; $display("FAIL b2b_first_result: got %0d/%0d want 14/2", dout, rem); end
        tick();
        checks++; if (ap_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_ready: got %b want 1", ap_ready); end
        ap_start = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (!ap_done && lat < 40);
        checks++; if (lat != 8 || !ap_done) begin errors++; $display("FAIL b2b_second_latency: got %0d want 8", lat); end
        checks++; if (dout !== 7'd11 || rem !== 5'd0) begin errors++; $display("FAIL b2b_second_result: got %0d/%0d want 11/0", dout, rem); end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ce_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fiat_25519_carry_square_udiv_7ns_5ns_7_seq.md
# fiat_25519_carry_square_udiv_7ns_5ns_7_seq

Sequential unsigned restoring divider: the inverse of the 3×5→7 unsigned multiplier used in the carry-square datapath. It takes a 7-bit dividend and a 5-bit divisor and returns a 7-bit quotient and a 5-bit remainder, producing one quotient bit per cycle under an ap-style start/done handshake. It sits next to the multiplier instances in the carry-square datapath and undoes constant and limb scalings.

## Interface
- din0_WIDTH, 7, dividend width
- din1_WIDTH, 5, divisor width
- dout_WIDTH, 7, quotient width (must equal din0_WIDTH)
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst  in  1  reset, synchronous, active-high
- ce  in  1  clock enable; when low, all state frozen
- ap_start  in  1  request; operands sampled when accepted
- din0  in  din0_WIDTH  unsigned dividend
- din1  in  din1_WIDTH  unsigned divisor
- ap_ready  out  1  operands accepted this cycle
- ap_idle  out  1  FSM in IDLE
- ap_done  out  1  one-cycle pulse: dout/rem valid
- dout  out  dout_WIDTH  quotient, held until next acceptance
- rem  out  din1_WIDTH  remainder, held until next acceptance
- div_by_zero  out  1  divisor was zero (see Configuration)

## Operation
- Reset: state IDLE; ap_ready=0, ap_done=0, ap_idle=1, dout=0, rem=0, div_by_zero=0.
- States: IDLE, CALC, DONE. All transitions require ce=1.
- IDLE: if ap_start=1, latch din0/din1, clear the partial remainder, load bit counter = din0_WIDTH-1, pulse ap_ready, go to CALC. Otherwise stay in IDLE.
- CALC, each cycle:
  - Form trial = {partial_rem, next dividend bit MSB-first}, width din1_WIDTH+1.
  - If trial ≥ divisor: partial_rem = trial − divisor and the quotient bit is 1. Otherwise partial_rem = trial[din1_WIDTH-1:0] and the quotient bit is 0.
  - Shift the quotient bit into the quotient LSB.
  - When counter = 0, go to DONE; otherwise decrement.
- DONE: drive dout and rem from the internal registers, pulse ap_done, return to IDLE.
- Divisor zero: the algorithm is run unmodified. This yields quotient = all ones (127) and rem = dividend[din1_WIDTH-1:0]. No special path.
- ap_start during CALC/DONE: ignored. No queueing.
- ap_rst mid-operation: abort, return to reset values next cycle. No ap_done is produced.

## Timing
- Acceptance cycle T (ap_ready=1). CALC occupies T+1 … T+din0_WIDTH. ap_done=1 in T+din0_WIDTH+1 (8 with defaults).
- Throughput: one division per din0_WIDTH+2 cycles. A new ap_start is accepted the cycle after ap_done at the earliest.
- ce=0 stretches every phase cycle-for-cycle; ap_ready/ap_done pulses are held until the next ce=1 edge.
- dout/rem/div_by_zero change only on the DONE edge and are stable otherwise.

## Configuration
- FIAT_25519_UDIV_DIV_ZERO_FLAG_EN defined: the divisor==0 compare is registered at acceptance; div_by_zero is updated with dout at DONE and held with it.
- Not defined: div_by_zero tied to 0 and the compare logic is absent. The quotient and remainder behaviour is identical in both builds.

## Structure
- Package fiat_25519_udiv_pkg: state enum (IDLE, CALC, DONE), default width localparams, counter width = $clog2(din0_WIDTH).
- Sub-module fiat_25519_udiv_step: combinational single restoring step. Inputs: partial remainder, dividend bit, divisor. Outputs: next remainder, quotient bit. Instantiated once inside the FSM.

## Test plan
- 100/7 started at T → ap_ready at T, ap_done at T+8 with dout=14, rem=2, div_by_zero=0.
- 127/1 → dout=127, rem=0. 5/31 → dout=0, rem=5. 126/18 → dout=7, rem=0.
- 45/0 → dout=127, rem=13. div_by_zero=1 with the macro, 0 without it.
- 100/7 with ce low for 3 cycles during CALC → ap_done at T+11, same results. ap_start pulsed during CALC is ignored.
- ap_rst asserted at T+4 of an operation → next cycle ap_idle=1, dout=0, rem=0, no ap_done. A fresh 50/6 then gives dout=8, rem=2 at latency 8.
- Back-to-back 100/7 then 99/9 with ap_start held high → second ap_ready the cycle after the first ap_done. Results 14/2 then 11/0.
